// File: rtl/control_unit_pkg.sv
// Shared symbols for the 8-bit core sequencer: FSM state encodings,
// instruction class codes and SYS sub-opcodes.
package control_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CL_ALU = 2'b00,
        CL_IN  = 2'b01,
        CL_OUT = 2'b10,
        CL_SYS = 2'b11
    } cls_t;

    localparam logic [2:0] SYS_NOP  = 3'b000;
    localparam logic [2:0] SYS_HALT = 3'b001;
    localparam logic [2:0] SYS_JMP  = 3'b010;

    function automatic cls_t ir_class(input logic [7:0] instr);
        return cls_t'(instr[7:6]);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetches into ir, steps ALU / IO / writeback
// from decoded fields, and owns the program counter.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [7:0]      ir,
    input  logic [2:0]      dec_operand_1,
    input  logic [2:0]      dec_operand_2,
    output logic            alu_start,
    input  logic            alu_done,
    output logic            in_req,
    input  logic            in_valid,
    output logic            out_we,
    input  logic            out_ready,
    output logic [2:0]      reg_raddr,
    input  logic [PC_W-1:0] reg_rdata,
    output logic            reg_we,
    output logic [2:0]      reg_waddr,
    output logic            wb_sel,
    output logic            busy,
    output logic            halted
);

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    cls_t            cls;
    logic            is_jmp;
    logic            is_halt;
    logic            fetch_done;

    assign cls        = ir_class(ir);
    assign is_jmp     = (cls == CL_SYS) && (dec_operand_1 == SYS_JMP);
    assign is_halt    = (cls == CL_SYS) && (dec_operand_1 == SYS_HALT);
    assign fetch_done = (state == S_FETCH) && imem_valid;
    assign imem_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ir loads only on the FETCH->DECODE edge; JMP overrides the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (fetch_done) begin
                pc <= pc + PC_W'(1);
                ir <= imem_data;
            end else if (state == S_EXEC && is_jmp) begin
                pc <= reg_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        alu_start = 1'b0;
        in_req    = 1'b0;
        out_we    = 1'b0;
        reg_we    = 1'b0;
        reg_raddr = 3'd0;
        reg_waddr = 3'd0;
        wb_sel    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                unique case (cls)
                    CL_ALU: begin
                        alu_start = 1'b1;
                        state_nxt = S_WAIT;
                    end
                    CL_IN: begin
                        in_req    = 1'b1;
                        state_nxt = S_WAIT;
                    end
                    CL_OUT: begin
                        out_we    = 1'b1;
                        reg_raddr = dec_operand_2;
                        if (out_ready) state_nxt = S_FETCH;
                    end
                    CL_SYS: begin
                        if (is_jmp) reg_raddr = dec_operand_2;
                        state_nxt = is_halt ? S_HALT : S_FETCH;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_WAIT: begin
                // alu_done only matters here; IN keeps requesting until data
                if (cls == CL_IN) begin
                    in_req = 1'b1;
                    if (in_valid) state_nxt = S_WB;
                end else if (alu_done) begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                reg_we    = 1'b1;
                reg_waddr = dec_operand_1;
                wb_sel    = (cls == CL_IN);
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks ALU, IN, OUT, JMP, NOP wrap,
// HALT and mid-instruction reset with hand-computed expectations.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_valid;
    logic [7:0] imem_data;
    logic [7:0] ir;
    logic [2:0] dec_operand_1;
    logic [2:0] dec_operand_2;
    logic       alu_start;
    logic       alu_done;
    logic       in_req;
    logic       in_valid;
    logic       out_we;
    logic       out_ready;
    logic [2:0] reg_raddr;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic [2:0] reg_waddr;
    logic       wb_sel;
    logic       busy;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    // stand-in for the core-level decoder
    assign dec_operand_1 = ir[5:3];
    assign dec_operand_2 = ir[2:0];

    always #5 clk = ~clk;

    control_unit #(.PC_W(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .ir(ir),
        .dec_operand_1(dec_operand_1), .dec_operand_2(dec_operand_2),
        .alu_start(alu_start), .alu_done(alu_done),
        .in_req(in_req), .in_valid(in_valid),
        .out_we(out_we), .out_ready(out_ready),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .wb_sel(wb_sel),
        .busy(busy), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {alu_start, in_req, out_we, reg_we};
    endfunction

    initial begin
        rst = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_data = 8'h00;
        alu_done = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        reg_rdata = 8'h00;
        #22;
        check("rst_imem_req", imem_req, 0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_ir", ir, 8'h00);
        check("rst_strobes", strobes(), 4'b0000);
        check("rst_busy_halt", {busy, halted}, 2'b00);
        check("rst_regaddr", {reg_raddr, reg_waddr, wb_sel}, 7'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_no_run", imem_req, 0);

        // ALU 00_011_111
        run = 1'b1;
        tick();
        run = 1'b0;
        check("fetch_req", {imem_req, busy}, 2'b11);
        check("fetch_addr0", imem_addr, 8'h00);
        imem_data = 8'b00_011_111; imem_valid = 1'b1;
        cnt = 0;
        tick(); cnt++;
        imem_valid = 1'b0;
        check("alu_ir", ir, 8'h1F);
        check("alu_pc1", imem_addr, 8'h01);
        check("alu_decode_quiet", strobes(), 4'b0000);
        tick(); cnt++;
        check("alu_start", strobes(), 4'b1000);
        tick(); cnt++;
        check("alu_start_1cyc", strobes(), 4'b0000);
        alu_done = 1'b1;
        tick(); cnt++;
        alu_done = 1'b0;
        check("alu_wb", strobes(), 4'b0001);
        check("alu_waddr", reg_waddr, 3'd3);
        check("alu_wbsel", wb_sel, 0);
        tick(); cnt++;
        check("alu_next_fetch", imem_req, 1);
        check("alu_latency", cnt, 5);

        // IN 01_010_101, in_valid after 4 cycles
        imem_data = 8'b01_010_101; imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        check("in_pc2", imem_addr, 8'h02);
        tick();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) in_valid = 1'b1;
            if (in_req) cnt++;
            if (strobes() != 4'b0100 && strobes() != 4'b0000) n_err++;
            tick();
        end
        in_valid = 1'b0;
        check("in_req_cycles", cnt, 5);
        check("in_wb", strobes(), 4'b0001);
        check("in_waddr", reg_waddr, 3'd2);
        check("in_wbsel", wb_sel, 1);
        tick();

        // OUT 10_100_001 with FETCH stall of 2 cycles
        check("out_fetch", imem_req, 1);
        tick(); tick();
        check("fetch_stall", {imem_req, ir}, {1'b1, 8'h55});
        imem_data = 8'b10_100_001; imem_valid = 1'b1;
        tick();
        imem_valid = 1'b0;
        tick();
        check("out_raddr", reg_raddr, 3'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            if (out_we) cnt++;
            if (reg_we) cnt += 100;
            tick();
        end
        out_ready = 1'b0;
        check("out_we_cycles", cnt, 4);
        check("out_back_fetch", {imem_req, imem_addr}, {1'b1, 8'h03});

        // JMP 11_010_110 -> 0x40
        imem_data = 8'b11_010_110; imem_valid = 1'b1; reg_rdata = 8'h40;
        tick();
        imem_valid = 1'b0;
        tick();
        check("jmp_raddr", reg_raddr, 3'd6);
        check("jmp_quiet", strobes(), 4'b0000);
        tick();
        check("jmp_target", {imem_req, imem_addr}, {1'b1, 8'h40});

        // JMP to 0xFF, then NOP there wraps pc
        imem_valid = 1'b1; reg_rdata = 8'hFF;
        tick(); imem_valid = 1'b0;
        tick(); tick();
        check("jmp_ff", imem_addr, 8'hFF);
        imem_data = 8'b11_000_000; imem_valid = 1'b1;
        cnt = 0;
        tick(); cnt++;
        imem_valid = 1'b0;
        check("nop_wrap", imem_addr, 8'h00);
        tick(); cnt++;
        check("nop_quiet", strobes(), 4'b0000);
        tick(); cnt++;
        check("nop_next", {imem_req, imem_addr}, {1'b1, 8'h00});
        check("nop_latency", cnt, 3);

        // HALT 11_001_000
        imem_data = 8'b11_001_000; imem_valid = 1'b1;
        tick(); imem_valid = 1'b0;
        tick(); tick();
        check("halt_flags", {halted, busy, imem_req}, 3'b100);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            imem_valid = 1'b1;
            tick();
            if (imem_req || !halted) cnt++;
        end
        run = 1'b0; imem_valid = 1'b0;
        check("halt_sticky", cnt, 0);

        // reset mid-WAIT of an ALU op
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        imem_data = 8'b00_101_010; imem_valid = 1'b1;
        tick(); imem_valid = 1'b0;
        tick(); tick();
        check("pre_rst_wait", {busy, strobes()}, 5'b10000);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", {busy, halted, imem_req, imem_addr, ir},
              {3'b000, 8'h00, 8'h00});
        check("async_rst_strb", strobes(), 4'b0000);
        alu_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (reg_we || out_we) cnt++;
        end
        check("no_wb_after_rst", cnt, 0);
        alu_done = 1'b0;
        rst = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        check("restart_pc0", {imem_req, imem_addr}, {1'b1, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
